uart_tx_buffered: RTL and testbench
===================================

# uart_tx_buffered

Parametrised, buffered successor to the fixed-message UART transmitter that drives `io_out[0]` in the tiny-tapeout top level. It accepts parallel words over a valid/ready handshake into an internal FIFO and serialises them on `tx_pin` LSB-first. Data width, parity, stop bits, baud rate and buffer depth are configurable. A `tx_enable` gate allows flow control.

## Interface
Parameters:
- `CLOCK_RATE`, 1000: `clk` frequency in Hz.
- `BAUD_RATE`, 100: line rate. `DIV = CLOCK_RATE/BAUD_RATE` must be an integer ≥ 2; elaboration fails otherwise.
- `DATA_BITS`, 8: word width, legal range 5..9.
- `PARITY`, 0: 0 = none, 1 = odd, 2 = even.
- `STOP_BITS`, 1: 1 or 2.
- `FIFO_DEPTH`, 4: power of two, ≥ 2.

Ports:
- `clk` in 1: single clock; all logic is on the rising edge.
- `reset` in 1: synchronous, active-low.
- `data_in` in DATA_BITS: word to transmit.
- `valid_in` in 1: `data_in` is valid.
- `ready_out` out 1: FIFO can accept a word; equals `!full`; forced 0 while `reset` is low.
- `tx_enable` in 1: when low, no new frame starts; a frame already in progress completes.
- `tx_pin` out 1: serial line, idle high; registered.
- `busy` out 1: high from the first start-bit cycle to the last stop-bit cycle; registered.
- `fifo_count` out $clog2(FIFO_DEPTH)+1: current FIFO occupancy.

## Operation
- Push: occurs on an edge where `valid_in && ready_out`. When full, `ready_out` = 0 and `valid_in` is ignored; data is never overwritten.
- Frame format: start bit (0), then `DATA_BITS` LSB-first, then an optional parity bit, then `STOP_BITS` × 1.
  - Even parity bit = XOR of the data bits.
  - Odd parity bit = its inverse.
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE → START: when FIFO non-empty and `tx_enable` = 1. The FIFO head is popped into the shift register on that edge.
  - START → DATA: after DIV cycles.
  - DATA → PARITY (or STOP if `PARITY` = 0): after `DATA_BITS` × DIV cycles.
  - PARITY → STOP: after DIV cycles.
  - STOP lasts `STOP_BITS` × DIV cycles. On its final edge, if FIFO non-empty and `tx_enable` = 1, the FSM pops and goes directly to START (no idle gap); otherwise it goes to IDLE.
- Counters:
  - Baud counter: $clog2(DIV) bits, counts 0..DIV-1, wraps to 0 at each bit boundary.
  - Bit counter: counts data bits 0..DATA_BITS-1, then stop bits.
- Simultaneous push and pop: `fifo_count` is unchanged and the pointers advance independently. This is legal, including at count = 1 (the pop takes the old head).
- `tx_enable` falling mid-frame: the frame finishes and the FSM holds in IDLE. The FIFO continues accepting words until full.

## Timing
- Reset values: `tx_pin` = 1, `busy` = 0, `fifo_count` = 0, FSM = IDLE, pointers = 0, `ready_out` = 0 during reset and 1 on the first cycle after release.
- Reset asserted mid-frame: the frame is aborted; `tx_pin` = 1 after the next edge; FIFO contents are discarded.
- Latency: a word accepted at edge k into an empty FIFO with the FSM idle is popped at edge k+1. `tx_pin` goes low and `busy` goes high after edge k+1, i.e. two cycles from acceptance.
- Every bit lasts exactly DIV cycles. Frame length = DIV × (1 + DATA_BITS + (PARITY≠0) + STOP_BITS).
- `fifo_count` updates on the push/pop edge. `ready_out` is combinational from `fifo_count` (and `reset`).

## Structure
- Package `uart_pkg`: parity constants `PARITY_NONE`/`PARITY_ODD`/`PARITY_EVEN`, FSM state enum, and a frame-length function.
- Sub-module `sync_fifo` (parameters WIDTH, DEPTH):
  - Pointers are one bit wider than the address so full and empty are distinguishable.
  - Provides a registered count output.
  - Read data is combinational from the head.
- The top level holds the FSM, baud counter, shift register and parity accumulator.

## Test plan
- Defaults (DIV=10, 8N1): push 0x55 → `tx_pin` sequence 0,1,0,1,0,1,0,1,0,1, each level held 10 cycles; start bit appears 2 cycles after accept; `busy` high for 100 cycles.
- PARITY=2, STOP_BITS=2, push 0x07 → parity bit 1 followed by two stop bits; frame is 120 cycles.
- PARITY=1, DATA_BITS=7, push 0x00 → parity bit 1; frame is 100 cycles.
- FIFO_DEPTH=4: push 6 words back-to-back → `ready_out` drops after the 5th accept (4 buffered + 1 in flight). All accepted words are transmitted in order with no idle gap between frames.
- Drop `tx_enable` mid-frame with 2 words queued → current frame completes, `tx_pin` stays 1, `fifo_count` = 2. Raise `tx_enable` → next start bit after 1 cycle.
- Assert `reset` during the DATA state → `tx_pin` = 1, `busy` = 0 and `fifo_count` = 0 after the next edge; after release, a new push transmits correctly.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared definitions for the buffered UART transmitter: parity modes,
// transmitter FSM states and a frame-length helper.
package uart_pkg;

    localparam int PARITY_NONE = 0;
    localparam int PARITY_ODD  = 1;
    localparam int PARITY_EVEN = 2;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } tx_state_t;

    // Clock cycles occupied by one complete frame on the line.
    function automatic int frame_len(input int div, input int data_bits,
                                     input int parity, input int stop_bits);
        return div * (1 + data_bits + ((parity != PARITY_NONE) ? 1 : 0) + stop_bits);
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with wrap-bit pointers, registered occupancy count and
// combinational read data from the head entry.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     wr_en,
    input  logic [WIDTH-1:0]         wr_data,
    output logic                     full,
    input  logic                     rd_en,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             push;
    logic             pop;

    // Same address with differing wrap bits means the writer has lapped the reader.
    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign push    = wr_en && !full;
    assign pop     = rd_en && !empty;
    assign rd_data = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset && push) begin
            mem[wr_ptr[AW-1:0]] <= wr_data;
        end
    end

endmodule

// File: rtl/uart_tx_buffered.sv
// Buffered UART transmitter: words enter a FIFO over valid/ready and are
// serialised LSB-first with optional parity and one or two stop bits.
module uart_tx_buffered
    import uart_pkg::*;
#(
    parameter int CLOCK_RATE = 1000,
    parameter int BAUD_RATE  = 100,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [DATA_BITS-1:0]          data_in,
    input  logic                          valid_in,
    output logic                          ready_out,
    input  logic                          tx_enable,
    output logic                          tx_pin,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam int DIV = CLOCK_RATE / BAUD_RATE;
    localparam int BW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int NW  = $clog2(DATA_BITS + 1);

    if (DIV < 2 || (CLOCK_RATE % BAUD_RATE) != 0) begin : g_bad_div
        $error("uart_tx_buffered: CLOCK_RATE/BAUD_RATE must be an integer >= 2");
    end
    if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_width
        $error("uart_tx_buffered: DATA_BITS must be 5..9");
    end
    if (PARITY < PARITY_NONE || PARITY > PARITY_EVEN) begin : g_bad_parity
        $error("uart_tx_buffered: PARITY must be 0, 1 or 2");
    end
    if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop
        $error("uart_tx_buffered: STOP_BITS must be 1 or 2");
    end
    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("uart_tx_buffered: FIFO_DEPTH must be a power of two >= 2");
    end

    tx_state_t               state;
    logic [BW-1:0]           baud_cnt;
    logic [NW-1:0]           bit_cnt;
    logic [DATA_BITS-1:0]    shift_reg;
    logic                    parity_acc;
    logic                    parity_bit;
    logic [DATA_BITS-1:0]    fifo_head;
    logic                    fifo_full;
    logic                    fifo_empty;
    logic                    can_start;
    logic                    baud_last;
    logic                    frame_end;
    logic                    pop;

    assign ready_out  = reset && !fifo_full;
    assign can_start  = !fifo_empty && tx_enable;
    assign baud_last  = (baud_cnt == BW'(DIV - 1));
    assign frame_end  = (state == S_STOP) && baud_last && (bit_cnt == NW'(STOP_BITS - 1));
    // Popping on the final stop edge lets back-to-back frames run with no idle gap.
    assign pop        = can_start && ((state == S_IDLE) || frame_end);
    assign parity_bit = (PARITY == PARITY_EVEN) ? parity_acc : !parity_acc;

    sync_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (valid_in),
        .wr_data (data_in),
        .full    (fifo_full),
        .rd_en   (pop),
        .rd_data (fifo_head),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            state      <= S_IDLE;
            baud_cnt   <= '0;
            bit_cnt    <= '0;
            shift_reg  <= '0;
            parity_acc <= 1'b0;
            tx_pin     <= 1'b1;
            busy       <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (pop) begin
                        state      <= S_START;
                        baud_cnt   <= '0;
                        bit_cnt    <= '0;
                        shift_reg  <= fifo_head;
                        parity_acc <= 1'b0;
                        tx_pin     <= 1'b0;
                        busy       <= 1'b1;
                    end
                end

                S_START: begin
                    if (baud_last) begin
                        state      <= S_DATA;
                        baud_cnt   <= '0;
                        bit_cnt    <= '0;
                        tx_pin     <= shift_reg[0];
                        parity_acc <= parity_acc ^ shift_reg[0];
                        shift_reg  <= shift_reg >> 1;
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end

                S_DATA: begin
                    if (baud_last) begin
                        baud_cnt <= '0;
                        if (bit_cnt == NW'(DATA_BITS - 1)) begin
                            bit_cnt <= '0;
                            if (PARITY != PARITY_NONE) begin
                                state  <= S_PARITY;
                                tx_pin <= parity_bit;
                            end else begin
                                state  <= S_STOP;
                                tx_pin <= 1'b1;
                            end
                        end else begin
                            bit_cnt    <= bit_cnt + 1'b1;
                            tx_pin     <= shift_reg[0];
                            parity_acc <= parity_acc ^ shift_reg[0];
                            shift_reg  <= shift_reg >> 1;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end

                S_PARITY: begin
                    if (baud_last) begin
                        state    <= S_STOP;
                        baud_cnt <= '0;
                        bit_cnt  <= '0;
                        tx_pin   <= 1'b1;
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end

                S_STOP: begin
                    if (baud_last) begin
                        baud_cnt <= '0;
                        if (bit_cnt == NW'(STOP_BITS - 1)) begin
                            bit_cnt <= '0;
                            if (pop) begin
                                state      <= S_START;
                                shift_reg  <= fifo_head;
                                parity_acc <= 1'b0;
                                tx_pin     <= 1'b0;
                                busy       <= 1'b1;
                            end else begin
                                state  <= S_IDLE;
                                tx_pin <= 1'b1;
                                busy   <= 1'b0;
                            end
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end

                default: begin
                    state  <= S_IDLE;
                    tx_pin <= 1'b1;
                    busy   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_buffered.sv
// Two transmitter configurations (8N1 DIV=10 depth 4; 7O2 DIV=4 depth 2) share
// one stimulus stream and are checked every cycle against a queue/frame model.
module tb_uart_tx_buffered;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       valid = 1'b0;
    logic       tx_en = 1'b1;
    logic [7:0] data = 8'h00;

    logic       rdy_a, tx_a, busy_a;
    logic [2:0] cnt_a;
    logic       rdy_b, tx_b, busy_b;
    logic [1:0] cnt_b;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    uart_tx_buffered dut_a (
        .clk        (clk),
        .reset      (rst),
        .data_in    (data),
        .valid_in   (valid),
        .ready_out  (rdy_a),
        .tx_enable  (tx_en),
        .tx_pin     (tx_a),
        .busy       (busy_a),
        .fifo_count (cnt_a)
    );

    uart_tx_buffered #(
        .CLOCK_RATE (1000),
        .BAUD_RATE  (250),
        .DATA_BITS  (7),
        .PARITY     (1),
        .STOP_BITS  (2),
        .FIFO_DEPTH (2)
    ) dut_b (
        .clk        (clk),
        .reset      (rst),
        .data_in    (data[6:0]),
        .valid_in   (valid),
        .ready_out  (rdy_b),
        .tx_enable  (tx_en),
        .tx_pin     (tx_b),
        .busy       (busy_b),
        .fifo_count (cnt_b)
    );

    // Per-instance configuration.
    function automatic int c_div(input int i);   return (i == 0) ? 10 : 4; endfunction
    function automatic int c_db(input int i);    return (i == 0) ? 8 : 7;  endfunction
    function automatic int c_par(input int i);   return (i == 0) ? 0 : 1;  endfunction
    function automatic int c_stop(input int i);  return (i == 0) ? 1 : 2;  endfunction
    function automatic int c_depth(input int i); return (i == 0) ? 4 : 2;  endfunction

    function automatic int flen(input int i);
        return c_div(i) * (1 + c_db(i) + ((c_par(i) != 0) ? 1 : 0) + c_stop(i));
    endfunction

    // Line levels of a whole frame, bit k = level during the k-th bit period.
    function automatic logic [15:0] build(input int i, input logic [8:0] w);
        logic [15:0] f;
        logic        p;
        f    = 16'hFFFF;
        f[0] = 1'b0;
        p    = 1'b0;
        for (int b = 0; b < c_db(i); b++) begin
            f[1+b] = w[b];
            p      = p ^ w[b];
        end
        if (c_par(i) == 2) f[1+c_db(i)] = p;
        if (c_par(i) == 1) f[1+c_db(i)] = ~p;
        return f;
    endfunction

    task automatic chk(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
        end
    endtask

    logic [8:0]  mq [2][8];
    int          qh [2] = '{0, 0};
    int          qn [2] = '{0, 0};
    int          pos[2] = '{0, 0};
    bit          act[2] = '{0, 0};
    logic [15:0] frm[2] = '{16'hFFFF, 16'hFFFF};

    // Reference model, advanced on each rising edge from the inputs held before it.
    initial begin
        forever begin
            @(posedge clk);
            for (int i = 0; i < 2; i++) begin
                if (!rst) begin
                    qh[i]  = 0;
                    qn[i]  = 0;
                    act[i] = 1'b0;
                    pos[i] = 0;
                end else begin
                    bit push;
                    push = valid && (qn[i] < c_depth(i));
                    if (act[i]) begin
                        pos[i]++;
                        if (pos[i] == flen(i)) act[i] = 1'b0;
                    end
                    if (!act[i] && qn[i] > 0 && tx_en) begin
                        frm[i] = build(i, mq[i][qh[i]]);
                        qh[i]  = (qh[i] + 1) % 8;
                        qn[i]--;
                        act[i] = 1'b1;
                        pos[i] = 0;
                    end
                    if (push) begin
                        mq[i][(qh[i] + qn[i]) % 8] = (i == 0) ? {1'b0, data} : {2'b00, data[6:0]};
                        qn[i]++;
                    end
                end
            end
        end
    end

    // Cycle-by-cycle comparison of both instances against the model.
    initial begin
        forever begin
            @(negedge clk);
            chk("tx_a",    int'(tx_a),   act[0] ? int'(frm[0][pos[0] / c_div(0)]) : 1);
            chk("busy_a",  int'(busy_a), int'(act[0]));
            chk("count_a", int'(cnt_a),  qn[0]);
            chk("ready_a", int'(rdy_a),  int'(rst && (qn[0] < c_depth(0))));
            chk("tx_b",    int'(tx_b),   act[1] ? int'(frm[1][pos[1] / c_div(1)]) : 1);
            chk("busy_b",  int'(busy_b), int'(act[1]));
            chk("count_b", int'(cnt_b),  qn[1]);
            chk("ready_b", int'(rdy_b),  int'(rst && (qn[1] < c_depth(1))));
        end
    end

    task automatic wait_idle(input string name);
        bit done;
        done = 1'b0;
        for (int k = 0; k < 3000; k++) begin
            @(posedge clk); #1;
            if (!act[0] && !act[1] && qn[0] == 0 && qn[1] == 0) begin
                done = 1'b1;
                break;
            end
        end
        chk(name, int'(done), 1);
    endtask

    initial begin
        logic [15:0] f;
        int          n;
        int          acc;
        bit          r;

        // Pin the model against hand-computed frames.
        f = build(0, 9'h055);
        chk("model_frame_8n1_55", int'(f[9:0]), 'h2AA);
        chk("model_len_8n1", flen(0), 100);
        f = build(1, 9'h000);
        chk("model_frame_7o2_00", int'(f[10:0]), 'h700);
        chk("model_len_7o2", flen(1), 44);

        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        chk("ready_after_release", int'(rdy_a), 1);

        // Single word: start bit two cycles after presenting it, busy for a full frame.
        @(posedge clk); #1;
        valid = 1'b1;
        data  = 8'h55;
        n = 0;
        for (int k = 0; k < 10; k++) begin
            @(posedge clk); #1;
            valid = 1'b0;
            n++;
            if (tx_a == 1'b0) break;
        end
        chk("start_latency", n, 2);
        n = 0;
        for (int k = 0; k < 300; k++) begin
            if (!busy_a) break;
            n++;
            @(posedge clk); #1;
        end
        chk("busy_len", n, 100);
        wait_idle("drain_single");

        // Back-to-back burst until the depth-4 FIFO refuses.
        acc   = 0;
        valid = 1'b1;
        data  = 8'($urandom);
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            r = rdy_a;
            @(posedge clk); #1;
            if (!r) break;
            acc++;
            data = 8'($urandom);
        end
        valid = 1'b0;
        chk("burst_accepts", acc, 5);
        chk("burst_full", int'(cnt_a), 4);
        wait_idle("drain_burst");

        // Flow control: drop tx_enable mid-frame with two words waiting.
        for (int k = 0; k < 3; k++) begin
            valid = 1'b1;
            data  = 8'($urandom);
            @(posedge clk); #1;
        end
        valid = 1'b0;
        repeat (30) @(posedge clk);
        #1 tx_en = 1'b0;
        for (int k = 0; k < 200; k++) begin
            @(posedge clk); #1;
            if (!act[0]) break;
        end
        chk("hold_count", int'(cnt_a), 2);
        repeat (20) @(posedge clk);
        #1 chk("hold_line", int'(tx_a), 1);
        tx_en = 1'b1;
        @(posedge clk); #1;
        chk("restart_start_bit", int'(tx_a), 0);
        wait_idle("drain_enable");

        // Reset in the middle of the data bits.
        valid = 1'b1;
        data  = 8'hC3;
        @(posedge clk); #1;
        valid = 1'b0;
        for (int k = 0; k < 200; k++) begin
            @(posedge clk); #1;
            if (act[0] && pos[0] >= 25) break;
        end
        rst   = 1'b0;
        valid = 1'b1;
        @(posedge clk); #1;
        chk("reset_tx", int'(tx_a), 1);
        chk("reset_busy", int'(busy_a), 0);
        chk("reset_count", int'(cnt_a), 0);
        rst   = 1'b1;
        valid = 1'b1;
        data  = 8'hA5;
        @(posedge clk); #1;
        valid = 1'b0;
        wait_idle("drain_after_reset");

        // Randomised traffic with occasional flow-control gaps and resets.
        for (int k = 0; k < 4000; k++) begin
            valid = ($urandom_range(0, 2) != 0);
            data  = 8'($urandom);
            tx_en = ($urandom_range(0, 15) != 0);
            rst   = ($urandom_range(0, 999) != 0);
            @(posedge clk); #1;
        end
        valid = 1'b0;
        tx_en = 1'b1;
        rst   = 1'b1;
        wait_idle("drain_random");

        @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
